time_epoch_decoder: RTL and testbench
=====================================

Name: time_epoch_decoder

Overview:
- Synthesizable gmtime engine: converts unsigned seconds-since-1970-01-01 00:00:00 UTC into broken-down struct_time fields (tm_sec … tm_yday, C struct tm semantics, UTC only, no DST).
- Inverse direction of svtime::mktime: the hardware-side decoder for epoch values delivered by the DPI/testbench layer.
- Sits beside time_monitor/time_alarmclock.
- Iterative multi-cycle engine with valid/ready on both sides.

Parameters:
- EPOCH_W, 40, width of input epoch, unsigned; legal range 32..48.
- YEAR_W, 16, width of out_tm_year; must hold max year-1900 for EPOCH_W.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  engine idle, accepts request
- in_epoch  input  EPOCH_W  seconds since epoch, unsigned
- out_valid  output  1  result valid, held until accepted
- out_ready  input  1  consumer accepts result
- out_tm_sec  output  6  0..59
- out_tm_min  output  6  0..59
- out_tm_hour  output  5  0..23
- out_tm_mday  output  5  1..31
- out_tm_mon  output  4  0..11
- out_tm_year  output  YEAR_W  years since 1900
- out_tm_wday  output  3  0=Sunday..6
- out_tm_yday  output  9  0..365
- busy  output  1  high in any state other than IDLE and DONE

Behaviour:
- Reset (async, rst_n low):
  - State = IDLE; in_ready = 1; out_valid = 0; busy = 0.
  - All tm outputs = 0.
  - A reset mid-operation aborts the conversion; no partial result is ever presented.
- Request acceptance: the request is accepted on a clock edge with in_valid && in_ready. in_epoch is registered; in_ready drops the next cycle and stays low until the result is accepted.
- FSM states: IDLE → DIVDAY → HMS → WDAY → YEAR → MONTH → DONE → IDLE.
- DIVDAY:
  - Restoring division of the epoch by 86400, one quotient bit per cycle, EPOCH_W cycles.
  - days = quotient, width EPOCH_W-16.
  - sod = remainder, 17 bits.
- HMS:
  - Subtract 3600 from sod while sod ≥ 3600, incrementing hour each time (≤23 cycles).
  - Then subtract 60 while sod ≥ 60, incrementing min each time (≤59 cycles).
  - The residue is sec.
  - One subtraction per cycle.
- WDAY:
  - Restoring division of (days+4) by 7; the remainder is wday.
  - Uses days bit-width cycles.
  - 1970-01-01 was a Thursday, so wday = 4 for days = 0.
- YEAR:
  - Year counter starts at 70 (since 1900).
  - Leap tracking uses mod counters, no division: m4 = 2, m100 = 70, m400 = 370 at start; each wraps at 4/100/400.
  - leap = (m4 == 0) && ((m100 != 0) || (m400 == 0)).
  - ylen = leap ? 366 : 365.
  - While days ≥ ylen: days -= ylen, year += 1, advance the mod counters. One year per cycle.
  - On exit, yday = days, and the final year's leap flag is latched.
- MONTH:
  - Month lengths are 31,28/29,31,30,31,30,31,31,30,31,30,31; Feb = 29 iff the latched leap flag is set.
  - While days ≥ mlen(mon): days -= mlen, mon += 1.
  - On exit, mday = days + 1.
  - ≤11 cycles.
- DONE:
  - All tm outputs are updated in the same cycle out_valid rises, and are stable while out_valid = 1.
  - out_valid stays high until out_valid && out_ready; then IDLE with in_ready = 1 on the next cycle.
  - The tm outputs keep their last values in IDLE.
- Latency:
  - Variable, data-dependent.
  - Minimum about 2*EPOCH_W; no fixed bound, because the YEAR loop is about 1 cycle per year.
  - For epoch < 2^32, latency < 2*EPOCH_W + 300 cycles.
- Backpressure: out_ready low in DONE holds the result indefinitely; in_valid is ignored while in_ready = 0.
- Boundaries:
  - Epoch 0 gives 1970-01-01 00:00:00.
  - Year 2000 is leap (m400 = 0); 2100 is not.
  - The 1→2 digit wrap of each field is exercised via 23:59:59 → next day.
  - Max EPOCH_W input must not overflow YEAR_W at default parameters; this is asserted at elaboration.
- No combinational path from in_* or out_ready to any output.

Test Plan:
- Reset, then epoch 0 → sec/min/hour = 0, mday = 1, mon = 0, year = 70, wday = 4, yday = 0.
- Epoch 86399 → 23:59:59, mday = 1, mon = 0, year = 70, wday = 4. Then epoch 86400 → 00:00:00, mday = 2, wday = 5, yday = 1.
- Epoch 951782400 → 2000-02-29 00:00:00: mon = 1, mday = 29, year = 100, wday = 2, yday = 59 (leap-by-400 path).
- Epoch 1000000000 → 01:46:40, mday = 9, mon = 8, year = 101, wday = 0, yday = 251. Hold out_ready low 20 cycles: out_valid and fields stable, in_ready = 0.
- Epoch 2147483647 → 03:14:07, mday = 19, mon = 0, year = 138, wday = 2, yday = 18. Back-to-back requests with out_ready = 1 are accepted without loss.
- Assert rst_n low mid-YEAR state:
  - All outputs go to their reset values asynchronously.
  - After release, a new request decodes correctly.
  - Random epochs < 2^32 compared against svtime gmtime via DPI.

Source files
------------

// File: rtl/time_epoch_decoder_if.sv
// Request/result bundle for the epoch decoder: epoch in, broken-down UTC fields out.
interface time_epoch_decoder_if #(
  parameter int EPOCH_W = 40,
  parameter int YEAR_W  = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [EPOCH_W-1:0] in_epoch;
  logic               out_valid;
  logic               out_ready;
  logic [5:0]         out_tm_sec;
  logic [5:0]         out_tm_min;
  logic [4:0]         out_tm_hour;
  logic [4:0]         out_tm_mday;
  logic [3:0]         out_tm_mon;
  logic [YEAR_W-1:0]  out_tm_year;
  logic [2:0]         out_tm_wday;
  logic [8:0]         out_tm_yday;
  logic               busy;

  modport slave (
    input  in_valid, in_epoch, out_ready,
    output in_ready, out_valid, out_tm_sec, out_tm_min, out_tm_hour, out_tm_mday,
           out_tm_mon, out_tm_year, out_tm_wday, out_tm_yday, busy
  );

  modport master (
    output in_valid, in_epoch, out_ready,
    input  in_ready, out_valid, out_tm_sec, out_tm_min, out_tm_hour, out_tm_mday,
           out_tm_mon, out_tm_year, out_tm_wday, out_tm_yday, busy
  );
endinterface

// File: rtl/time_epoch_decoder.sv
// Iterative gmtime: seconds since 1970 -> struct tm fields (UTC).
// States: IDLE -> DIVDAY -> HMS -> WDAY -> YEAR -> MONTH -> DONE -> IDLE.
module time_epoch_decoder #(
  parameter int EPOCH_W = 40,
  parameter int YEAR_W  = 16
) (
  input  logic clk,
  input  logic rst_n,
  time_epoch_decoder_if.slave bus
);
  localparam int DAYS_W = EPOCH_W - 16;
  localparam longint unsigned MAX_DAYS = ((64'd1 << EPOCH_W) - 64'd1) / 64'd86400;
  localparam longint unsigned MAX_YEAR = MAX_DAYS / 64'd365 + 64'd71;

  if (EPOCH_W < 32 || EPOCH_W > 48) begin : g_bad_epoch_w
    $error("time_epoch_decoder: EPOCH_W must be in 32..48");
  end
  if (MAX_YEAR >= (64'd1 << YEAR_W)) begin : g_bad_year_w
    $error("time_epoch_decoder: YEAR_W too narrow for the largest epoch");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_DIVDAY, S_HMS, S_WDAY, S_YEAR, S_MONTH, S_DONE
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [EPOCH_W-1:0]  r_q;
  logic [16:0]         r_rem;
  logic [5:0]          r_cnt;
  logic [4:0]          r_hour;
  logic [5:0]          r_min, r_sec;
  logic [DAYS_W-1:0]   r_wsh;
  logic [2:0]          r_wrem;
  logic [YEAR_W-1:0]   r_year;
  logic [1:0]          r_m4;
  logic [6:0]          r_m100;
  logic [8:0]          r_m400;
  logic                r_leap;
  logic [8:0]          r_yday;
  logic [3:0]          r_mon;

  logic [5:0]          r_tm_sec, r_tm_min;
  logic [4:0]          r_tm_hour, r_tm_mday;
  logic [3:0]          r_tm_mon;
  logic [YEAR_W-1:0]   r_tm_year;
  logic [2:0]          r_tm_wday;
  logic [8:0]          r_tm_yday;

  logic [17:0]         w_dtrial;
  logic                w_dge;
  logic [3:0]          w_wtrial;
  logic                w_wge;
  logic [2:0]          w_wrem_nxt;
  logic [DAYS_W-1:0]   w_days;
  logic                w_leap;
  logic [8:0]          w_ylen;
  logic                w_year_ge;
  logic [4:0]          w_mlen;
  logic                w_mon_ge;
  logic                w_cnt_zero;

  assign w_dtrial   = {r_rem, r_q[EPOCH_W-1]};
  assign w_dge      = (w_dtrial >= 18'd86400);
  assign w_wtrial   = {r_wrem, r_wsh[DAYS_W-1]};
  assign w_wge      = (w_wtrial >= 4'd7);
  assign w_wrem_nxt = w_wge ? 3'(w_wtrial - 4'd7) : w_wtrial[2:0];
  assign w_days     = r_q[DAYS_W-1:0];
  assign w_leap     = (r_m4 == 2'd0) && ((r_m100 != 7'd0) || (r_m400 == 9'd0));
  assign w_ylen     = w_leap ? 9'd366 : 9'd365;
  assign w_year_ge  = (w_days >= DAYS_W'(w_ylen));
  assign w_mon_ge   = (w_days >= DAYS_W'(w_mlen));
  assign w_cnt_zero = (r_cnt == 6'd0);

  always_comb begin
    w_mlen = 5'd31;
    case (r_mon)
      4'd1:                      w_mlen = r_leap ? 5'd29 : 5'd28;
      4'd3, 4'd5, 4'd8, 4'd10:   w_mlen = 5'd30;
      default:                   w_mlen = 5'd31;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (bus.in_valid)        w_state_nxt = S_DIVDAY;
      S_DIVDAY: if (w_cnt_zero)          w_state_nxt = S_HMS;
      S_HMS:    if (r_rem < 17'd60)      w_state_nxt = S_WDAY;
      S_WDAY:   if (w_cnt_zero)          w_state_nxt = S_YEAR;
      S_YEAR:   if (!w_year_ge)          w_state_nxt = S_MONTH;
      S_MONTH:  if (!w_mon_ge)           w_state_nxt = S_DONE;
      S_DONE:   if (bus.out_ready)       w_state_nxt = S_IDLE;
      default:                           w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (r_state == S_IDLE);
    bus.out_valid = (r_state == S_DONE);
    bus.busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  end

  assign bus.out_tm_sec  = r_tm_sec;
  assign bus.out_tm_min  = r_tm_min;
  assign bus.out_tm_hour = r_tm_hour;
  assign bus.out_tm_mday = r_tm_mday;
  assign bus.out_tm_mon  = r_tm_mon;
  assign bus.out_tm_year = r_tm_year;
  assign bus.out_tm_wday = r_tm_wday;
  assign bus.out_tm_yday = r_tm_yday;

  // r_q holds the dividend, then the quotient (days), then the running day remainder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;  r_rem <= '0;  r_cnt <= '0;  r_hour <= '0;  r_min <= '0;  r_sec <= '0;
      r_wsh <= '0;  r_wrem <= '0;  r_year <= '0;  r_m4 <= '0;  r_m100 <= '0;  r_m400 <= '0;
      r_leap <= 1'b0;  r_yday <= '0;  r_mon <= '0;
      r_tm_sec <= '0;  r_tm_min <= '0;  r_tm_hour <= '0;  r_tm_mday <= '0;
      r_tm_mon <= '0;  r_tm_year <= '0;  r_tm_wday <= '0;  r_tm_yday <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.in_valid) begin
          r_q    <= bus.in_epoch;
          r_rem  <= '0;
          r_cnt  <= 6'(EPOCH_W - 1);
          r_hour <= '0;
          r_min  <= '0;
        end
        S_DIVDAY: begin
          r_rem <= w_dge ? 17'(w_dtrial - 18'd86400) : w_dtrial[16:0];
          r_q   <= {r_q[EPOCH_W-2:0], w_dge};
          if (!w_cnt_zero) r_cnt <= r_cnt - 6'd1;
        end
        S_HMS: begin
          if (r_rem >= 17'd3600) begin
            r_rem  <= r_rem - 17'd3600;
            r_hour <= r_hour + 5'd1;
          end else if (r_rem >= 17'd60) begin
            r_rem <= r_rem - 17'd60;
            r_min <= r_min + 6'd1;
          end else begin
            r_sec  <= r_rem[5:0];
            r_wsh  <= w_days + DAYS_W'(4);
            r_wrem <= '0;
            r_cnt  <= 6'(DAYS_W - 1);
            r_year <= YEAR_W'(70);
            r_m4   <= 2'd2;
            r_m100 <= 7'd70;
            r_m400 <= 9'd370;
          end
        end
        S_WDAY: begin
          r_wsh  <= {r_wsh[DAYS_W-2:0], 1'b0};
          r_wrem <= w_wrem_nxt;
          if (!w_cnt_zero) r_cnt <= r_cnt - 6'd1;
        end
        S_YEAR: begin
          if (w_year_ge) begin
            r_q    <= r_q - EPOCH_W'(w_ylen);
            r_year <= r_year + YEAR_W'(1);
            r_m4   <= r_m4 + 2'd1;
            r_m100 <= (r_m100 == 7'd99)  ? 7'd0 : r_m100 + 7'd1;
            r_m400 <= (r_m400 == 9'd399) ? 9'd0 : r_m400 + 9'd1;
          end else begin
            r_yday <= w_days[8:0];
            r_leap <= w_leap;
            r_mon  <= '0;
          end
        end
        S_MONTH: begin
          if (w_mon_ge) begin
            r_q   <= r_q - EPOCH_W'(w_mlen);
            r_mon <= r_mon + 4'd1;
          end else begin
            r_tm_sec  <= r_sec;
            r_tm_min  <= r_min;
            r_tm_hour <= r_hour;
            r_tm_mday <= w_days[4:0] + 5'd1;
            r_tm_mon  <= r_mon;
            r_tm_year <= r_year;
            r_tm_wday <= r_wrem;
            r_tm_yday <= r_yday;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_time_epoch_decoder.sv
// Scoreboard bench for time_epoch_decoder: directed epochs with hand-computed tm fields.
module tb_time_epoch_decoder;
  typedef struct packed {
    logic [5:0]  sec;
    logic [5:0]  min;
    logic [4:0]  hour;
    logic [4:0]  mday;
    logic [3:0]  mon;
    logic [15:0] year;
    logic [2:0]  wday;
    logic [8:0]  yday;
  } tm_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  tm_t  exp_q[$];
  tm_t  m_got, m_exp, x;

  always #5 clk = ~clk;

  time_epoch_decoder_if #(.EPOCH_W(40), .YEAR_W(16)) bus ();
  time_epoch_decoder #(.EPOCH_W(40), .YEAR_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic tm_t mk(int sec, int min, int hour, int mday, int mon, int year, int wday, int yday);
    tm_t t;
    t.sec = 6'(sec);  t.min = 6'(min);  t.hour = 5'(hour);  t.mday = 5'(mday);
    t.mon = 4'(mon);  t.year = 16'(year);  t.wday = 3'(wday);  t.yday = 9'(yday);
    return t;
  endfunction

  function automatic tm_t cur();
    tm_t t;
    t = {bus.out_tm_sec, bus.out_tm_min, bus.out_tm_hour, bus.out_tm_mday,
         bus.out_tm_mon, bus.out_tm_year, bus.out_tm_wday, bus.out_tm_yday};
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      m_got = cur();
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got %h required none", m_got);
      end else begin
        m_exp = exp_q.pop_front();
        chk("result", 64'(m_got), 64'(m_exp));
      end
    end
  end

  task automatic send(input logic [39:0] e, input tm_t t);
    int n = 0;
    while (!bus.in_ready && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_epoch = e;
    @(posedge clk);
    exp_q.push_back(t);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_hs"}, {61'd0, bus.in_ready, bus.out_valid, bus.busy}, 64'b100);
    chk({nm, "_fields"}, 64'(cur()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_epoch = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset_init");
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(40'd0, mk(0, 0, 0, 1, 0, 70, 4, 0));
    wait_drain();
    send(40'd86399, mk(59, 59, 23, 1, 0, 70, 4, 0));
    send(40'd86400, mk(0, 0, 0, 2, 0, 70, 5, 1));
    wait_drain();
    send(40'd951782400, mk(0, 0, 0, 29, 1, 100, 2, 59));
    wait_drain();
    send(40'd4107542400, mk(0, 0, 0, 1, 2, 200, 1, 59));
    wait_drain();

    // Backpressure: hold the result, poke in_valid while it is being held.
    bus.out_ready = 1'b0;
    x = mk(40, 46, 1, 9, 8, 101, 0, 251);
    send(40'd1000000000, x);
    n = 0;
    while (!bus.out_valid && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        bus.in_valid = 1'b1;
        bus.in_epoch = 40'd5;
      end
      chk("hold_stable", {8'd0, bus.out_valid, bus.in_ready, 54'(cur())}, {8'd0, 1'b1, 1'b0, 54'(x)});
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_drain();

    send(40'd2147483647, mk(7, 14, 3, 19, 0, 138, 2, 18));
    send(40'd86399, mk(59, 59, 23, 1, 0, 70, 4, 0));
    send(40'd86400, mk(0, 0, 0, 2, 0, 70, 5, 1));
    wait_drain();

    // Reset deep inside the year loop; the aborted conversion must never appear.
    send(40'd4107542400, mk(0, 0, 0, 1, 2, 200, 1, 59));
    repeat (120) @(posedge clk);
    #1;
    chk("busy_mid_year", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #2;
    check_reset("reset_async");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(40'd1000000000, mk(40, 46, 1, 9, 8, 101, 0, 251));
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
